// File: rtl/mem_burst_ctrl_if.sv
// rtl/mem_burst_ctrl_if.sv - command, write/read stream and memory-side signals of the burst controller
interface mem_burst_ctrl_if #(
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 4
);
    logic                  cmd_valid_i;
    logic                  cmd_ready_o;
    logic                  cmd_wr_i;
    logic [ADDR_WIDTH-1:0] cmd_addr_i;
    logic [ADDR_WIDTH:0]   cmd_len_i;

    logic                  wd_valid_i;
    logic                  wd_ready_o;
    logic [WIDTH-1:0]      wd_data_i;

    logic                  rd_valid_o;
    logic                  rd_ready_i;
    logic [WIDTH-1:0]      rd_data_o;

    logic [ADDR_WIDTH-1:0] addr_o;
    logic [WIDTH-1:0]      wdata_o;
    logic [WIDTH-1:0]      rdata_i;
    logic                  wr_rd_o;
    logic                  valid_o;
    logic                  ready_i;

    logic                  busy_o;
    logic                  done_o;
    logic                  err_o;

    modport master (
        input  cmd_valid_i, cmd_wr_i, cmd_addr_i, cmd_len_i,
        output cmd_ready_o,
        input  wd_valid_i, wd_data_i,
        output wd_ready_o,
        input  rd_ready_i,
        output rd_valid_o, rd_data_o,
        output addr_o, wdata_o, wr_rd_o, valid_o,
        input  rdata_i, ready_i,
        output busy_o, done_o, err_o
    );

    modport slave (
        output cmd_valid_i, cmd_wr_i, cmd_addr_i, cmd_len_i,
        input  cmd_ready_o,
        output wd_valid_i, wd_data_i,
        input  wd_ready_o,
        output rd_ready_i,
        input  rd_valid_o, rd_data_o,
        input  addr_o, wdata_o, wr_rd_o, valid_o,
        output rdata_i, ready_i,
        input  busy_o, done_o, err_o
    );
endinterface

// File: rtl/mem_burst_ctrl.sv
// rtl/mem_burst_ctrl.sv - burst front-end sequencing per-word accesses to a valid/ready memory
module mem_burst_ctrl #(
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    mem_burst_ctrl_if.master   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH:0] LEN_MAX = (ADDR_WIDTH+1)'(DEPTH);

    state_t                state, state_n;
    logic [ADDR_WIDTH-1:0] base_addr, base_addr_n;
    logic [ADDR_WIDTH:0]   len, len_n;
    logic [ADDR_WIDTH:0]   issued, issued_n;
    logic [ADDR_WIDTH:0]   completed, completed_n;

    logic                  mem_valid, mem_valid_n;
    logic                  mem_wr, mem_wr_n;
    logic [ADDR_WIDTH-1:0] mem_addr, mem_addr_n;
    logic [WIDTH-1:0]      mem_wdata, mem_wdata_n;
    logic                  rd_valid, rd_valid_n;
    logic [WIDTH-1:0]      rd_data, rd_data_n;
    logic                  busy, busy_n;
    logic                  done, done_n;
    logic                  err, err_n;

    logic                  cmd_ready;
    logic                  cmd_len_bad;
    logic                  wd_ready;
    logic                  wd_fire;
    logic                  mem_fire;
    logic                  rd_req;
    logic                  rd_take;
    logic [ADDR_WIDTH-1:0] beat_addr;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            base_addr <= '0;
            len       <= '0;
            issued    <= '0;
            completed <= '0;
            mem_valid <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            base_addr <= base_addr_n;
            len       <= len_n;
            issued    <= issued_n;
            completed <= completed_n;
            mem_valid <= mem_valid_n;
            mem_wr    <= mem_wr_n;
            mem_addr  <= mem_addr_n;
            mem_wdata <= mem_wdata_n;
            rd_valid  <= rd_valid_n;
            rd_data   <= rd_data_n;
            busy      <= busy_n;
            done      <= done_n;
            err       <= err_n;
        end
    end

    always_comb begin
        state_n     = state;
        base_addr_n = base_addr;
        len_n       = len;
        issued_n    = issued;
        completed_n = completed;
        mem_valid_n = mem_valid;
        mem_wr_n    = mem_wr;
        mem_addr_n  = mem_addr;
        mem_wdata_n = mem_wdata;
        rd_valid_n  = rd_valid;
        rd_data_n   = rd_data;
        err_n       = 1'b0;

        cmd_ready   = (state == IDLE);
        cmd_len_bad = (bus.cmd_len_i == '0) || (bus.cmd_len_i > LEN_MAX);
        mem_fire    = mem_valid && bus.ready_i;
        wd_ready    = (state == WRITE) && (issued < len) && (!mem_valid || bus.ready_i);
        wd_fire     = wd_ready && bus.wd_valid_i;
        // Only one read may be outstanding and the output word must have room.
        rd_req      = (state == READ) && !mem_valid && (issued < len) &&
                      (!rd_valid || bus.rd_ready_i);
        rd_take     = rd_valid && bus.rd_ready_i;
        beat_addr   = base_addr + issued[ADDR_WIDTH-1:0];

        unique case (state)
            IDLE: begin
                if (bus.cmd_valid_i) begin
                    if (cmd_len_bad) begin
                        err_n = 1'b1;
                    end else begin
                        base_addr_n = bus.cmd_addr_i;
                        len_n       = bus.cmd_len_i;
                        issued_n    = '0;
                        completed_n = '0;
                        state_n     = bus.cmd_wr_i ? WRITE : READ;
                    end
                end
            end
            WRITE: begin
                if (wd_fire) begin
                    mem_valid_n = 1'b1;
                    mem_wr_n    = 1'b1;
                    mem_addr_n  = beat_addr;
                    mem_wdata_n = bus.wd_data_i;
                    issued_n    = issued + 1'b1;
                end else if (mem_fire) begin
                    mem_valid_n = 1'b0;
                end
                if (mem_fire) begin
                    completed_n = completed + 1'b1;
                end
                if (completed_n == len) begin
                    state_n = DONE;
                end
            end
            READ: begin
                if (rd_req) begin
                    mem_valid_n = 1'b1;
                    mem_wr_n    = 1'b0;
                    mem_addr_n  = beat_addr;
                    issued_n    = issued + 1'b1;
                end
                // A returning word reloads the output register even if the old one drains now.
                if (mem_fire) begin
                    mem_valid_n = 1'b0;
                    rd_valid_n  = 1'b1;
                    rd_data_n   = bus.rdata_i;
                end else if (rd_take) begin
                    rd_valid_n  = 1'b0;
                end
                if (rd_take) begin
                    completed_n = completed + 1'b1;
                end
                if ((completed_n == len) && !rd_valid_n) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n = (state_n != IDLE);
        done_n = (state_n == DONE);
    end

    assign bus.cmd_ready_o = cmd_ready;
    assign bus.wd_ready_o  = wd_ready;
    assign bus.rd_valid_o  = rd_valid;
    assign bus.rd_data_o   = rd_data;
    assign bus.addr_o      = mem_addr;
    assign bus.wdata_o     = mem_wdata;
    assign bus.wr_rd_o     = mem_wr;
    assign bus.valid_o     = mem_valid;
    assign bus.busy_o      = busy;
    assign bus.done_o      = done;
    assign bus.err_o       = err;

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// tb/tb_mem_burst_ctrl.sv - directed self-checking bench for mem_burst_ctrl
module tb_mem_burst_ctrl;

    logic clk_i;
    logic rst_i;

    mem_burst_ctrl_if #(.WIDTH(16), .ADDR_WIDTH(4)) bus ();

    mem_burst_ctrl #(.WIDTH(16), .DEPTH(16), .ADDR_WIDTH(4)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem [16];
    logic        mem_init;
    logic        mem_lat;
    logic        wait_done;

    // Memory model: ready either in the same cycle as valid or one cycle later.
    always @(posedge clk_i) begin
        if (rst_i || !bus.valid_o || bus.ready_i) wait_done <= 1'b0;
        else wait_done <= 1'b1;
    end
    assign bus.ready_i = bus.valid_o && (mem_lat ? wait_done : 1'b1);
    assign bus.rdata_i = mem[bus.addr_o];

    always @(posedge clk_i) begin
        if (mem_init) begin
            for (int i = 0; i < 16; i++) mem[i] <= 16'h5000 + 16'(i);
        end else if (bus.valid_o && bus.ready_i && bus.wr_rd_o) begin
            mem[bus.addr_o] <= bus.wdata_o;
        end
    end

    logic [3:0]  wr_addr_q [$];
    logic [15:0] wr_data_q [$];
    logic [15:0] rd_q [$];
    int          rd_req_cnt = 0;
    int          done_cnt = 0;
    int          err_cnt = 0;
    int          proto_err = 0;
    logic        stall_q = 1'b0;
    logic [3:0]  stall_addr;
    logic [15:0] stall_wdata;
    logic        stall_wr;

    always @(posedge clk_i) begin
        if (bus.valid_o && bus.ready_i) begin
            if (bus.wr_rd_o) begin
                wr_addr_q.push_back(bus.addr_o);
                wr_data_q.push_back(bus.wdata_o);
            end else begin
                rd_req_cnt++;
            end
        end
        if (bus.rd_valid_o && bus.rd_ready_i) rd_q.push_back(bus.rd_data_o);
        if (bus.done_o) done_cnt++;
        if (bus.err_o) err_cnt++;
        if (stall_q && (!bus.valid_o || bus.addr_o != stall_addr ||
                        bus.wdata_o != stall_wdata || bus.wr_rd_o != stall_wr))
            proto_err++;
        stall_q     <= bus.valid_o && !bus.ready_i && !rst_i;
        stall_addr  <= bus.addr_o;
        stall_wdata <= bus.wdata_o;
        stall_wr    <= bus.wr_rd_o;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send_cmd(input logic wr, input logic [3:0] addr, input logic [4:0] len);
        bus.cmd_valid_i = 1'b1;
        bus.cmd_wr_i    = wr;
        bus.cmd_addr_i  = addr;
        bus.cmd_len_i   = len;
        tick();
        bus.cmd_valid_i = 1'b0;
    endtask

    task automatic push_word(input logic [15:0] d);
        bit fired = 0;
        bus.wd_valid_i = 1'b1;
        bus.wd_data_i  = d;
        for (int i = 0; i < 50 && !fired; i++) begin
            if (bus.wd_ready_o) fired = 1;
            tick();
        end
        check("wd_accept", 32'(fired), 32'd1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && bus.busy_o; i++) tick();
        check("idle_timeout", 32'(bus.busy_o), 32'd0);
    endtask

    int wb, rb, db, eb;
    logic [15:0] w1 [4];
    logic [15:0] w3 [4];
    logic [15:0] r4 [4];
    int idx;

    initial begin
        w1 = '{16'h00A1, 16'h00B2, 16'h00C3, 16'h00D4};
        w3 = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        r4 = '{16'h3333, 16'h4444, 16'h00C3, 16'h00D4};
        bus.cmd_valid_i = 1'b0;
        bus.cmd_wr_i    = 1'b0;
        bus.cmd_addr_i  = '0;
        bus.cmd_len_i   = '0;
        bus.wd_valid_i  = 1'b0;
        bus.wd_data_i   = '0;
        bus.rd_ready_i  = 1'b1;
        mem_lat  = 1'b1;
        mem_init = 1'b1;
        rst_i    = 1'b1;
        tick();
        tick();
        rst_i    = 1'b0;
        mem_init = 1'b0;

        check("rst_cmd_ready", 32'(bus.cmd_ready_o), 32'd1);
        check("rst_valid", 32'(bus.valid_o), 32'd0);
        check("rst_busy", 32'(bus.busy_o), 32'd0);
        check("rst_done", 32'(bus.done_o), 32'd0);
        check("rst_err", 32'(bus.err_o), 32'd0);
        check("rst_addr", 32'(bus.addr_o), 32'd0);
        check("rst_rd_valid", 32'(bus.rd_valid_o), 32'd0);
        check("rst_rd_data", 32'(bus.rd_data_o), 32'd0);

        // Write addr 0 len 4, memory ready one cycle after valid
        wb = wr_addr_q.size(); db = done_cnt;
        send_cmd(1'b1, 4'd0, 5'd4);
        check("w1_busy", 32'(bus.busy_o), 32'd1);
        check("w1_cmd_ready", 32'(bus.cmd_ready_o), 32'd0);
        for (int i = 0; i < 4; i++) push_word(w1[i]);
        bus.wd_valid_i = 1'b0;
        wait_idle();
        check("w1_count", 32'(wr_addr_q.size() - wb), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("w1_addr%0d", i), 32'(wr_addr_q[wb+i]), 32'(i));
            check($sformatf("w1_data%0d", i), 32'(wr_data_q[wb+i]), 32'(w1[i]));
        end
        check("w1_done", 32'(done_cnt - db), 32'd1);

        // Read addr 0 len 4, memory ready same cycle
        mem_lat = 1'b0;
        wb = wr_addr_q.size(); rb = rd_q.size(); db = done_cnt;
        send_cmd(1'b0, 4'd0, 5'd4);
        check("r2_valid_t1", 32'(bus.valid_o), 32'd0);
        tick();
        check("r2_valid_t2", 32'(bus.valid_o), 32'd1);
        check("r2_wr_rd", 32'(bus.wr_rd_o), 32'd0);
        wait_idle();
        check("r2_count", 32'(rd_q.size() - rb), 32'd4);
        for (int i = 0; i < 4; i++)
            check($sformatf("r2_data%0d", i), 32'(rd_q[rb+i]), 32'(w1[i]));
        check("r2_no_writes", 32'(wr_addr_q.size() - wb), 32'd0);
        check("r2_done", 32'(done_cnt - db), 32'd1);

        // Write addr 14 len 4 wrapping, full throughput
        wb = wr_addr_q.size(); db = done_cnt;
        send_cmd(1'b1, 4'd14, 5'd4);
        for (int i = 0; i < 4; i++) push_word(w3[i]);
        bus.wd_valid_i = 1'b0;
        check("w3_done_early", 32'(bus.done_o), 32'd0);
        tick();
        check("w3_done_pulse", 32'(bus.done_o), 32'd1);
        tick();
        check("w3_done_end", 32'(bus.done_o), 32'd0);
        check("w3_busy_end", 32'(bus.busy_o), 32'd0);
        check("w3_count", 32'(wr_addr_q.size() - wb), 32'd4);
        check("w3_addr0", 32'(wr_addr_q[wb+0]), 32'd14);
        check("w3_addr1", 32'(wr_addr_q[wb+1]), 32'd15);
        check("w3_addr2", 32'(wr_addr_q[wb+2]), 32'd0);
        check("w3_addr3", 32'(wr_addr_q[wb+3]), 32'd1);

        rb = rd_q.size();
        send_cmd(1'b0, 4'd14, 5'd4);
        wait_idle();
        for (int i = 0; i < 4; i++)
            check($sformatf("w3_rb%0d", i), 32'(rd_q[rb+i]), 32'(w3[i]));

        // Read with consumer stalled for 5 cycles after first word
        bus.rd_ready_i = 1'b0;
        rb = rd_q.size();
        send_cmd(1'b0, 4'd0, 5'd4);
        for (int i = 0; i < 20 && !bus.rd_valid_o; i++) tick();
        for (int i = 0; i < 5; i++) begin
            check("r4_hold_valid", 32'(bus.rd_valid_o), 32'd1);
            check("r4_hold_data", 32'(bus.rd_data_o), 32'h3333);
            check("r4_no_issue", 32'(bus.valid_o), 32'd0);
            tick();
        end
        bus.rd_ready_i = 1'b1;
        wait_idle();
        check("r4_count", 32'(rd_q.size() - rb), 32'd4);
        for (int i = 0; i < 4; i++)
            check($sformatf("r4_data%0d", i), 32'(rd_q[rb+i]), 32'(r4[i]));

        // Illegal lengths
        eb = err_cnt; rb = rd_req_cnt; wb = wr_addr_q.size();
        send_cmd(1'b0, 4'd3, 5'd0);
        check("e0_err", 32'(bus.err_o), 32'd1);
        check("e0_busy", 32'(bus.busy_o), 32'd0);
        check("e0_valid", 32'(bus.valid_o), 32'd0);
        tick();
        check("e0_err_clear", 32'(bus.err_o), 32'd0);
        send_cmd(1'b1, 4'd3, 5'd17);
        check("e17_err", 32'(bus.err_o), 32'd1);
        check("e17_busy", 32'(bus.busy_o), 32'd0);
        check("e17_valid", 32'(bus.valid_o), 32'd0);
        tick();
        check("e17_err_clear", 32'(bus.err_o), 32'd0);
        check("e_err_count", 32'(err_cnt - eb), 32'd2);
        check("e_no_access", 32'(rd_req_cnt - rb + wr_addr_q.size() - wb), 32'd0);

        // Reset after the 2nd completion of a len-8 write
        mem_lat = 1'b1;
        wb = wr_addr_q.size(); db = done_cnt;
        send_cmd(1'b1, 4'd4, 5'd8);
        idx = 0;
        bus.wd_valid_i = 1'b1;
        bus.wd_data_i  = 16'h6000;
        for (int i = 0; i < 100 && (wr_addr_q.size() - wb) < 2; i++) begin
            if (bus.wd_ready_o) begin
                tick();
                idx++;
                bus.wd_data_i = 16'h6000 + 16'(idx);
            end else begin
                tick();
            end
        end
        check("x_two_done", 32'(wr_addr_q.size() - wb), 32'd2);
        rst_i = 1'b1;
        bus.wd_valid_i = 1'b0;
        tick();
        rst_i = 1'b0;
        check("x_valid", 32'(bus.valid_o), 32'd0);
        check("x_cmd_ready", 32'(bus.cmd_ready_o), 32'd1);
        check("x_busy", 32'(bus.busy_o), 32'd0);
        tick();
        tick();
        check("x_no_done", 32'(done_cnt - db), 32'd0);
        check("x_writes", 32'(wr_addr_q.size() - wb), 32'd2);
        rb = rd_q.size(); db = done_cnt;
        send_cmd(1'b0, 4'd4, 5'd2);
        wait_idle();
        check("x_rd_count", 32'(rd_q.size() - rb), 32'd2);
        check("x_rd0", 32'(rd_q[rb+0]), 32'h6000);
        check("x_rd1", 32'(rd_q[rb+1]), 32'h6001);
        check("x_rd_done", 32'(done_cnt - db), 32'd1);

        check("protocol", 32'(proto_err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
